// File: rtl/isqrt_if.sv
// Handshake bundle for the iterative square root: operand in, root/remainder out.
// The master drives operands and consumes results; the slave is the datapath.
interface isqrt_if #(parameter int W = 32);
  localparam int H = W / 2;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic         round_nearest;
  logic         out_valid;
  logic         out_ready;
  logic [H:0]   y;
  logic [H:0]   rem;

  modport master (
    output in_valid, x, round_nearest, out_ready,
    input  in_ready, out_valid, y, rem
  );

  modport slave (
    input  in_valid, x, round_nearest, out_ready,
    output in_ready, out_valid, y, rem
  );
endinterface

// File: rtl/isqrt_iter.sv
// Iterative restoring integer square root, one root bit per clock.
// Produces floor or round-to-nearest root plus the floor remainder.
module isqrt_iter #(
  parameter int W = 32
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   clear,
  isqrt_if.slave bus
);
  localparam int H = W / 2;
  localparam int CW = $clog2(H);
  localparam logic [CW-1:0] LAST = CW'(H - 1);
  localparam logic [W-1:0] M_INIT = {2'b01, {(W-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  tx, ty, m;
  logic [W-1:0]  b, tx_nxt, ty_nxt;
  logic [CW-1:0] cnt;
  logic          mode;
  logic [H:0]    y_r, rem_r, rem_fin;
  logic          accept, last;

  // Rem > root means x is past r^2 + r, so the nearest integer is r + 1.
  function automatic logic [H:0] round_root(input logic [H-1:0] root,
                                            input logic [H:0]   r,
                                            input logic         nearest);
    logic [H:0] base;
    base = {1'b0, root};
    return (nearest && (r > base)) ? base + (H+1)'(1) : base;
  endfunction

  assign accept = (state == IDLE) && bus.in_valid && !clear;
  assign last   = (state == CALC) && (cnt == LAST);

  always_comb begin
    b      = ty | m;
    tx_nxt = tx;
    ty_nxt = ty >> 1;
    if (tx >= b) begin
      tx_nxt = tx - b;
      ty_nxt = (ty >> 1) | m;
    end
  end

  assign rem_fin = tx_nxt[H:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx    <= '0;
      ty    <= '0;
      m     <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      y_r   <= '0;
      rem_r <= '0;
    end else if (accept) begin
      tx   <= bus.x;
      ty   <= '0;
      m    <= M_INIT;
      mode <= bus.round_nearest;
      cnt  <= '0;
    end else if ((state == CALC) && !clear) begin
      tx  <= tx_nxt;
      ty  <= ty_nxt;
      m   <= m >> 2;
      cnt <= cnt + CW'(1);
      if (last) begin
        y_r   <= round_root(ty_nxt[H-1:0], rem_fin, mode);
        rem_r <= rem_fin;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.y         = y_r;
  assign bus.rem       = rem_r;
endmodule

// File: doc/isqrt_iter.md
Name: isqrt_iter

Overview:
Parametrised iterative integer square root. It computes floor or round-to-nearest sqrt of a W-bit unsigned operand, one result bit per clock, and also returns the remainder. It uses valid/ready handshakes on both input and output, so it can sit between pipeline stages or stream sources in the fixed-point datapath. Only one operation is in flight at a time.

Parameters:
W, 32, input operand width in bits; must be even and >= 4 (H = W/2 below)

Ports:
clock  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous abort; returns to IDLE, drops out_valid
in_valid  input  1  operand offered
in_ready  output  1  block can accept an operand
x  input  W  unsigned operand, sampled on accept
round_nearest  input  1  mode, sampled on accept; 0 = floor, 1 = round to nearest
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
y  output  H+1  root; bit H is set only on round-nearest overflow
rem  output  H+1  floor remainder, x - floor(sqrt(x))^2, always

Behaviour:
- Reset is asynchronous on reset_n low. Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - y = 0, rem = 0
  - all internal registers = 0
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready at a rising edge: load tx = x, ty = 0, m = 1 << (W-2), latch round_nearest, step counter = 0, go to CALC.
  - in_valid is ignored in every other state.
- CALC:
  - in_ready = 0, out_valid = 0.
  - Each cycle runs one restoring iteration:
    - b = ty | m; ty >>= 1
    - if tx >= b then tx -= b, ty |= m
    - m >>= 2
  - Exactly H iterations. After the H-th, go to DONE.
- DONE:
  - Entered exactly H cycles after the accept edge; out_valid = 1 from that edge.
  - On entry: y = {0, ty[H-1:0]} when floor mode.
  - In round mode, if rem > ty then y = ty + 1, else y = ty. This uses an H+1-bit add, so x = 2^W - 1 gives y = 2^H.
  - rem = tx[H:0]. The remainder is at most 2*floor_root, so it fits in H+1 bits.
  - y and rem hold stable while out_valid = 1 and out_ready = 0 (backpressure has no time limit).
  - On out_valid & out_ready: out_valid drops next cycle, go to IDLE, in_ready = 1 next cycle.
  - in_ready = 0 throughout DONE, so there is no same-cycle reload.
  - Minimum spacing between accepts is H + 2 cycles.
- clear:
  - Has priority over all other events in every state.
  - Next state IDLE, out_valid = 0, y and rem retain their last values.
  - A clear in the same cycle as an accept discards that operand.
- Mid-operation reset: reset_n low in CALC or DONE aborts immediately to reset values. No output is produced for the aborted operand.
- Mode and operand are registered on accept. Later changes to x or round_nearest do not affect the operation in flight.
- Arithmetic: all comparisons are unsigned. Internal tx, ty, m and b are W bits wide.
- Round-nearest rule: rem > floor_root is equivalent to x >= r^2 + r + 1, which is the correct nearest-integer threshold. There is no exact tie for integers.

Test Plan:
- W=32, floor: x=0 -> y=0, rem=0. Then x=1000000 -> y=1000, rem=0. Then x=0xFFFFFFFF -> y=0x0FFFF, rem=0x1FFFE. out_valid rises exactly 16 cycles after each accept edge.
- W=32, round_nearest=1: x=24 -> y=5, rem=8. x=20 -> y=4, rem=4 (rem not > root). x=0xFFFFFFFF -> y=0x10000, rem=0x1FFFE. Same x=24 with floor -> y=4, rem=8.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid; y, rem and out_valid stay stable. in_ready stays 0 and a new in_valid is ignored. Release -> in_ready=1 the following cycle and the next accept succeeds.
- Reset and clear: assert reset_n=0 at CALC step 5 -> outputs go to reset values with no out_valid. Assert clear in DONE -> out_valid drops next cycle, in_ready=1, and the next operand x=144 returns y=12, rem=0.
- W=8 instance, exhaustive: all 256 x in both modes, back-to-back with random out_ready stalls. Check against a reference: y = floor(sqrt(x)) or nearest, rem = x - floor^2, latency 4 cycles. x=255 round -> y=16.
- Operand stability: change x and round_nearest every cycle during CALC -> the result matches the values sampled at the accept edge.
